// File: rtl/controle_telas.sv
// controle_telas: screen sequencer for the VGA output.
// Runs the INICIO/JOGO/DERROTA/VITORIA game-state FSM, picks which renderer
// drives the DAC, swaps screens only on frame boundaries, holds end screens
// for a minimum number of frames and pulses reset_jogo when a game starts.
// Optional build macro CONTROLE_TELAS_BLINK_EN makes the defeat screen blink.
module controle_telas #(
    parameter int H_ATIVO       = 640,
    parameter int V_ATIVO       = 480,
    parameter int MIN_QUADROS   = 60,
    parameter int CNT_W         = 8,
    parameter int BLINK_QUADROS = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  h_counter,
    input  logic [9:0]  v_counter,
    input  logic        btn_start,
    input  logic        evt_derrota,
    input  logic        evt_vitoria,
    input  logic [23:0] rgb_inicio,
    input  logic [23:0] rgb_jogo,
    input  logic [23:0] rgb_derrota,
    input  logic [23:0] rgb_vitoria,
    output logic [7:0]  R,
    output logic [7:0]  G,
    output logic [7:0]  B,
    output logic [1:0]  tela_sel,
    output logic        jogo_ativo,
    output logic        reset_jogo
);

    typedef enum logic [1:0] {
        INICIO  = 2'd0,
        JOGO    = 2'd1,
        DERROTA = 2'd2,
        VITORIA = 2'd3
    } estado_t;

    localparam logic [CNT_W-1:0] MIN_Q = CNT_W'(MIN_QUADROS);
    localparam logic [9:0]       H_LIM = 10'(H_ATIVO);
    localparam logic [9:0]       V_LIM = 10'(V_ATIVO);

    estado_t          estado, estado_prox;
    logic [CNT_W-1:0] cnt_quadros, cnt_prox;
    logic             orig, orig_prev, tick;
    logic             btn_prev, start;
    logic             reset_jogo_prox;
    logic [23:0]      rgb_sel;
    logic             ativo;
    logic             oculto;

    // Frame origin edge and button rising edge, both single-cycle events.
    assign orig  = (h_counter == 10'd0) && (v_counter == 10'd0);
    assign tick  = orig & ~orig_prev;
    assign start = btn_start & ~btn_prev;

    // Next-state logic: transitions, frame-count bookkeeping, restart pulse.
    always_comb begin
        estado_prox     = estado;
        cnt_prox        = cnt_quadros;
        reset_jogo_prox = 1'b0;
        case (estado)
            INICIO: begin
                if (start) begin
                    estado_prox     = JOGO;
                    reset_jogo_prox = 1'b1;
                end
            end
            JOGO: begin
                // Defeat wins when both events arrive together.
                if (evt_derrota) begin
                    estado_prox = DERROTA;
                    cnt_prox    = '0;
                end else if (evt_vitoria) begin
                    estado_prox = VITORIA;
                    cnt_prox    = '0;
                end
            end
            DERROTA, VITORIA: begin
                // Early presses are dropped; only a press after the hold time counts.
                if ((cnt_quadros == MIN_Q) && start) begin
                    estado_prox = INICIO;
                end else if (tick && (cnt_quadros != MIN_Q)) begin
                    cnt_prox = cnt_quadros + 1'b1;
                end
            end
            default: estado_prox = INICIO;
        endcase
    end

    // State register, edge-detect history and screen select latched on frame ticks.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado      <= INICIO;
            cnt_quadros <= '0;
            orig_prev   <= 1'b1;
            btn_prev    <= 1'b1;
            reset_jogo  <= 1'b0;
            jogo_ativo  <= 1'b0;
            tela_sel    <= 2'd0;
        end else begin
            estado      <= estado_prox;
            cnt_quadros <= cnt_prox;
            orig_prev   <= orig;
            btn_prev    <= btn_start;
            reset_jogo  <= reset_jogo_prox;
            jogo_ativo  <= (estado_prox == JOGO);
            if (tick) begin
                tela_sel <= estado;
            end
        end
    end

`ifdef CONTROLE_TELAS_BLINK_EN
    localparam int BW = (BLINK_QUADROS < 2) ? 1 : $clog2(BLINK_QUADROS);
    localparam logic [BW-1:0] BLINK_FIM = BW'(BLINK_QUADROS - 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_vis;

    // Defeat-screen blink: toggle visibility every BLINK_QUADROS frames.
    always_ff @(posedge clk) begin
        if (reset || (tela_sel != 2'd2)) begin
            blink_cnt <= '0;
            blink_vis <= 1'b1;
        end else if (tick) begin
            if (blink_cnt == BLINK_FIM) begin
                blink_cnt <= '0;
                blink_vis <= ~blink_vis;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign oculto = (tela_sel == 2'd2) && !blink_vis;
`else
    assign oculto = 1'b0;
`endif

    // Renderer mux driven by the displayed screen, not the live FSM state.
    always_comb begin
        rgb_sel = rgb_inicio;
        case (tela_sel)
            2'd0:    rgb_sel = rgb_inicio;
            2'd1:    rgb_sel = rgb_jogo;
            2'd2:    rgb_sel = rgb_derrota;
            default: rgb_sel = rgb_vitoria;
        endcase
    end

    assign ativo = (h_counter < H_LIM) && (v_counter < V_LIM);

    // Registered pixel output, blanked outside the active area.
    always_ff @(posedge clk) begin
        if (reset) begin
            {R, G, B} <= 24'd0;
        end else if (!ativo || oculto) begin
            {R, G, B} <= 24'd0;
        end else begin
            {R, G, B} <= rgb_sel;
        end
    end

endmodule

// File: tb/tb_controle_telas.sv
// tb_controle_telas: directed vector table plus randomized run against a
// frame-level reference model of the screen sequencer.
module tb_controle_telas;

    localparam int MINQ = 3;
    localparam int BQ   = 2;

    localparam logic [23:0] C_I = 24'h111111;
    localparam logic [23:0] C_J = 24'hFF8000;
    localparam logic [23:0] C_D = 24'hFFFFFF;
    localparam logic [23:0] C_V = 24'h00FF00;
`ifdef CONTROLE_TELAS_BLINK_EN
    localparam logic [23:0] C_DL = 24'h000000;
`else
    localparam logic [23:0] C_DL = 24'hFFFFFF;
`endif

    logic        clk, reset;
    logic [9:0]  h_counter, v_counter;
    logic        btn_start, evt_derrota, evt_vitoria;
    logic [23:0] rgb_inicio, rgb_jogo, rgb_derrota, rgb_vitoria;
    logic [7:0]  R, G, B;
    logic [1:0]  tela_sel;
    logic        jogo_ativo, reset_jogo;

    controle_telas #(
        .H_ATIVO(640), .V_ATIVO(480), .MIN_QUADROS(MINQ), .CNT_W(8), .BLINK_QUADROS(BQ)
    ) dut (
        .clk(clk), .reset(reset),
        .h_counter(h_counter), .v_counter(v_counter),
        .btn_start(btn_start), .evt_derrota(evt_derrota), .evt_vitoria(evt_vitoria),
        .rgb_inicio(rgb_inicio), .rgb_jogo(rgb_jogo),
        .rgb_derrota(rgb_derrota), .rgb_vitoria(rgb_vitoria),
        .R(R), .G(G), .B(B),
        .tela_sel(tela_sel), .jogo_ativo(jogo_ativo), .reset_jogo(reset_jogo)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: screen = game state name, frames counted without limit.
    int          m_state;   // 0 title, 1 game, 2 defeat, 3 victory
    int          m_frames;  // frames seen since entering an end screen
    int          m_blink;   // frames seen while defeat screen displayed
    bit          m_orig_prev, m_btn_prev;
    logic [1:0]  m_tela;
    logic [23:0] m_rgb;
    bit          m_rj, m_ja;

    task automatic model_clock();
        bit orig, tick, start;
        int old_state;
        if (reset) begin
            m_state = 0; m_frames = 0; m_blink = 0;
            m_orig_prev = 1; m_btn_prev = 1;
            m_tela = 2'd0; m_rgb = 24'd0; m_rj = 0; m_ja = 0;
        end else begin
            orig  = (h_counter == 0) && (v_counter == 0);
            tick  = orig && !m_orig_prev;
            start = btn_start && !m_btn_prev;
            // pixel for this clock uses the currently displayed screen
            if (int'(h_counter) >= 640 || int'(v_counter) >= 480) m_rgb = 24'd0;
            else begin
                case (m_tela)
                    2'd0: m_rgb = rgb_inicio;
                    2'd1: m_rgb = rgb_jogo;
                    2'd2: m_rgb = rgb_derrota;
                    default: m_rgb = rgb_vitoria;
                endcase
`ifdef CONTROLE_TELAS_BLINK_EN
                if (m_tela == 2'd2 && ((m_blink / BQ) % 2) == 1) m_rgb = 24'd0;
`endif
            end
            if (m_tela != 2'd2) m_blink = 0;
            else if (tick) m_blink++;
            old_state = m_state;
            m_rj = 0;
            case (m_state)
                0: if (start) begin m_state = 1; m_rj = 1; end
                1: begin
                    if (evt_derrota) begin m_state = 2; m_frames = 0; end
                    else if (evt_vitoria) begin m_state = 3; m_frames = 0; end
                end
                default: begin
                    if (start && m_frames >= MINQ) m_state = 0;
                    else if (tick) m_frames++;
                end
            endcase
            if (tick) m_tela = 2'(old_state);
            m_ja = (m_state == 1);
            m_orig_prev = orig;
            m_btn_prev  = btn_start;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // One clock: model advances with the same inputs, outputs sampled 1 after edge.
    task automatic step();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".rgb"}, 32'({R, G, B}), 32'(m_rgb));
        check({tag, ".tela"}, 32'(tela_sel), 32'(m_tela));
        check({tag, ".ativo"}, 32'(jogo_ativo), 32'(m_ja));
        check({tag, ".rj"}, 32'(reset_jogo), 32'(m_rj));
    endtask

    typedef struct {
        logic [9:0]  h, v;
        logic        btn, ed, ev;
        logic [1:0]  tela;
        logic        ja, rj;
        logic [23:0] rgb;
    } vec_t;

    vec_t tab[28];

    initial begin
        tab[0]  = '{10'd5,   10'd5,   1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, C_I};
        tab[1]  = '{10'd6,   10'd5,   1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, C_I};
        tab[2]  = '{10'd7,   10'd5,   1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, C_I};
        tab[3]  = '{10'd8,   10'd5,   1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, C_I};
        tab[4]  = '{10'd9,   10'd5,   1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, C_I};
        tab[5]  = '{10'd0,   10'd0,   1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, C_I};
        tab[6]  = '{10'd100, 10'd50,  1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, C_J};
        tab[7]  = '{10'd101, 10'd50,  1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, C_J};
        tab[8]  = '{10'd0,   10'd0,   1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, C_J};
        tab[9]  = '{10'd1,   10'd0,   1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, C_D};
        tab[10] = '{10'd2,   10'd0,   1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, C_D};
        tab[11] = '{10'd0,   10'd0,   1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, C_D};
        tab[12] = '{10'd3,   10'd0,   1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, C_D};
        tab[13] = '{10'd4,   10'd0,   1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, C_D};
        tab[14] = '{10'd0,   10'd0,   1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, C_D};
        tab[15] = '{10'd0,   10'd0,   1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, C_DL};
        tab[16] = '{10'd5,   10'd0,   1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, C_DL};
        tab[17] = '{10'd6,   10'd0,   1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, C_DL};
        tab[18] = '{10'd0,   10'd0,   1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, C_DL};
        tab[19] = '{10'd639, 10'd479, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, C_I};
        tab[20] = '{10'd0,   10'd0,   1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, C_I};
        tab[21] = '{10'd639, 10'd479, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, C_J};
        tab[22] = '{10'd640, 10'd479, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 24'd0};
        tab[23] = '{10'd10,  10'd480, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 24'd0};
        tab[24] = '{10'd0,   10'd1,   1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, C_J};
        tab[25] = '{10'd0,   10'd0,   1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, C_J};
        tab[26] = '{10'd20,  10'd20,  1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, C_V};
        tab[27] = '{10'd21,  10'd20,  1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, C_V};

        // Reset with the button held down
        reset = 1'b1; btn_start = 1'b1; evt_derrota = 1'b0; evt_vitoria = 1'b0;
        h_counter = 10'd5; v_counter = 10'd5;
        rgb_inicio = C_I; rgb_jogo = C_J; rgb_derrota = C_D; rgb_vitoria = C_V;
        step();
        step();
        check("reset.rgb", 32'({R, G, B}), 32'd0);
        check("reset.tela", 32'(tela_sel), 32'd0);
        check("reset.ativo", 32'(jogo_ativo), 32'd0);
        check("reset.rj", 32'(reset_jogo), 32'd0);
        reset = 1'b0;

        // Directed vector table
        for (int i = 0; i < 28; i++) begin
            h_counter = tab[i].h; v_counter = tab[i].v;
            btn_start = tab[i].btn; evt_derrota = tab[i].ed; evt_vitoria = tab[i].ev;
            step();
            check($sformatf("vec%0d.rgb", i), 32'({R, G, B}), 32'(tab[i].rgb));
            check($sformatf("vec%0d.tela", i), 32'(tela_sel), 32'(tab[i].tela));
            check($sformatf("vec%0d.ativo", i), 32'(jogo_ativo), 32'(tab[i].ja));
            check($sformatf("vec%0d.rj", i), 32'(reset_jogo), 32'(tab[i].rj));
        end

        // Reset mid-screen with the button pressed, then a fresh start
        reset = 1'b1; btn_start = 1'b1; evt_derrota = 1'b0; h_counter = 10'd30;
        step();
        check("midrst.tela", 32'(tela_sel), 32'd0);
        check("midrst.rgb", 32'({R, G, B}), 32'd0);
        check("midrst.rj", 32'(reset_jogo), 32'd0);
        reset = 1'b0; h_counter = 10'd31;
        step();
        check("held.ativo", 32'(jogo_ativo), 32'd0);
        check("held.rj", 32'(reset_jogo), 32'd0);
        btn_start = 1'b0;
        step();
        btn_start = 1'b1;
        step();
        check("restart.ativo", 32'(jogo_ativo), 32'd1);
        check("restart.rj", 32'(reset_jogo), 32'd1);
        step();
        check("restart.rj_once", 32'(reset_jogo), 32'd0);

        // Randomized run against the reference model
        for (int n = 0; n < 4000; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 2) begin
                h_counter = 10'd0; v_counter = 10'd0;
            end else if (r == 2) begin
                h_counter = ($urandom_range(0, 1) == 1) ? 10'd640 : 10'd639;
                v_counter = 10'($urandom_range(0, 479));
            end else if (r == 3) begin
                h_counter = 10'($urandom_range(0, 639));
                v_counter = ($urandom_range(0, 1) == 1) ? 10'd480 : 10'd479;
            end else begin
                h_counter = 10'($urandom_range(0, 799));
                v_counter = 10'($urandom_range(0, 524));
            end
            if ($urandom_range(0, 5) == 0) btn_start = ~btn_start;
            evt_derrota = ($urandom_range(0, 19) == 0);
            evt_vitoria = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 399) == 0);
            rgb_inicio = 24'($urandom); rgb_jogo = 24'($urandom);
            rgb_derrota = 24'($urandom); rgb_vitoria = 24'($urandom);
            step();
            check_model("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/controle_telas.md
Name: controle_telas

Overview:
- Screen sequencer for the game's VGA output.
- Runs the game-state FSM (INICIO, JOGO, DERROTA, VITORIA).
- Selects which renderer's RGB reaches the DAC: title, gameplay, defeat or victory. The defeat renderer is the combinational space-invader sprite screen.
- Switches screens only at frame boundaries, enforces a minimum end-screen display time, and pulses a restart to game logic.

Parameters:
H_ATIVO, 640, horizontal active pixels; RGB forced black at or beyond this column
V_ATIVO, 480, vertical active lines; RGB forced black at or beyond this line
MIN_QUADROS, 60, frames DERROTA/VITORIA must be shown before btn_start is accepted
CNT_W, 8, frame counter width; MIN_QUADROS must be less than 2^CNT_W
BLINK_QUADROS, 15, half-period in frames of the defeat-screen blink (BLINK_EN only)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
h_counter  input  10  current VGA column, from the sync generator
v_counter  input  10  current VGA line, from the sync generator
btn_start  input  1  start/restart button, already debounced, level
evt_derrota  input  1  game logic: player lost (pulse or level)
evt_vitoria  input  1  game logic: player won (pulse or level)
rgb_inicio  input  24  title renderer {R,G,B}
rgb_jogo  input  24  gameplay renderer {R,G,B}
rgb_derrota  input  24  defeat renderer {R,G,B}
rgb_vitoria  input  24  victory renderer {R,G,B}
R  output  8  red to DAC
G  output  8  green to DAC
B  output  8  blue to DAC
tela_sel  output  2  displayed screen: 0 INICIO, 1 JOGO, 2 DERROTA, 3 VITORIA
jogo_ativo  output  1  high while the FSM state is JOGO
reset_jogo  output  1  one-cycle pulse to reset game logic when entering JOGO

Behaviour:
- Everything is synchronous to clk. reset has priority over all other logic.
- Reset values:
  - FSM = INICIO; tela_sel = 0.
  - R/G/B = 0; reset_jogo = 0; jogo_ativo = 0.
  - Frame counter = 0; origin flag = 1; btn_prev = 1.
  - btn_prev resets to 1 so a button held through reset does not start a game.
- Frame tick:
  - orig = (h_counter==0 && v_counter==0).
  - tick = orig & ~orig_prev, so it lasts one clk even if the counters stall for several clocks.
- Button edge: start = btn_start & ~btn_prev. Only this rising edge is used.
- FSM transitions, evaluated every clk:
  - INICIO: start -> JOGO; reset_jogo = 1 on that same cycle.
  - JOGO, evt_derrota -> DERROTA; frame counter cleared.
  - JOGO, evt_vitoria -> VITORIA; frame counter cleared.
  - JOGO, both events asserted in the same cycle -> DERROTA (defeat has priority).
  - JOGO: start is ignored.
  - DERROTA/VITORIA: the counter increments on each tick and saturates at MIN_QUADROS.
  - DERROTA/VITORIA with counter == MIN_QUADROS and start -> INICIO.
  - DERROTA/VITORIA: start before saturation is discarded, not queued.
  - DERROTA/VITORIA: evt_* are ignored.
- jogo_ativo = (state == JOGO), registered with the state.
- reset_jogo is high for exactly one clk per INICIO->JOGO transition.
- tela_sel is loaded with the state encoding only on tick cycles. A state change mid-frame becomes visible on the next frame; no screen tearing.
- Pixel path (registered, 1 clk latency from h/v_counter to R/G/B):
  - If h_counter >= H_ATIVO or v_counter >= V_ATIVO: R=G=B=0.
  - Otherwise {R,G,B} = rgb input selected by tela_sel (R = bits 23:16, G = 15:8, B = 7:0).
- Reset asserted mid-game or mid-frame: the next clk shows the reset values. The FSM returns to INICIO with no reset_jogo pulse.

Optional Feature:
- Macro: CONTROLE_TELAS_BLINK_EN.
- When defined:
  - A BLINK-sized counter advances on tick while tela_sel==2.
  - Every BLINK_QUADROS frames the visibility phase toggles. The phase starts visible on entry to DERROTA.
  - During the invisible phase the active-area output is 0.
  - The counter and phase clear whenever tela_sel != 2.
- When undefined: no blink logic; the defeat screen is shown steadily.

Test Plan:
- Reset with btn_start held at 1, then release and press again -> no transition on the held level; the first rising edge after release gives state JOGO, a single reset_jogo pulse, and jogo_ativo=1.
- In JOGO, evt_derrota and evt_vitoria high in the same clk at h=100,v=50 -> state DERROTA immediately; tela_sel stays 1 until the next h=0,v=0 tick, then becomes 2.
- MIN_QUADROS=3; in DERROTA press start after 2 ticks -> ignored; press after 3 ticks -> INICIO, then tela_sel=0 at the next tick.
- tela_sel=1, rgb_jogo=24'hFF8000, h=639,v=479 -> R=FF,G=80,B=00 one clk later; at h=640 -> R=G=B=0.
- h/v held at 0,0 for 4 clks -> exactly one tick; the frame counter advances by 1.
- BLINK_EN, BLINK_QUADROS=2, rgb_derrota=24'hFFFFFF -> frames 0-1 white, frames 2-3 black, frames 4-5 white; without the macro, all frames white.
